tlc_multiway: RTL

Parametrised N-road traffic light controller, successor to the fixed two-road A/B controller. Replaces the external `timer_done` input with internal cycle counters for minimum green, maximum green, amber, all-red and red+amber phases. Serves per-road traffic requests in round-robin order. Sits between the road sensor synchronisers and the lamp driver outputs.

---
 rtl/tlc_pkg.sv | 17 +
 rtl/tlc_rr_pick.sv | 29 ++
 rtl/tlc_multiway.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tlc_pkg.sv
// Shared types and lamp encodings for the multi-road traffic light controller.
package tlc_pkg;

    typedef enum logic [1:0] {
        PH_GREEN     = 2'd0,
        PH_AMBER     = 2'd1,
        PH_ALL_RED   = 2'd2,
        PH_RED_AMBER = 2'd3
    } tlc_phase_e;

    // Per-road lamp triple is {red, amber, green}
    localparam logic [2:0] LAMP_RED       = 3'b100;
    localparam logic [2:0] LAMP_AMBER     = 3'b010;
    localparam logic [2:0] LAMP_GREEN     = 3'b001;
    localparam logic [2:0] LAMP_RED_AMBER = 3'b110;

endpackage

// File: rtl/tlc_rr_pick.sv
// Round-robin finder: first requesting road after cur (wrapping), cur itself excluded.
module tlc_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] cur,
    output logic          found,
    output logic [IW-1:0] idx
);

    int j;

    // Walk from the farthest candidate inward so the nearest requester wins.
    always_comb begin
        found = 1'b0;
        idx   = cur;
        j     = 0;
        for (int k = N - 1; k >= 1; k--) begin
            j = int'(cur) + k;
            if (j >= N) j = j - N;
            if (req[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/tlc_multiway.sv
// N-road traffic light controller with internal phase timers and round-robin service.
//
// state        | meaning
// PH_GREEN     | road g green, others red; timer saturates at MAX_GREEN-1
// PH_AMBER     | road g amber, others red
// PH_ALL_RED   | every road red (clearance)
// PH_RED_AMBER | road n red+amber, others red; g<=n on exit
module tlc_multiway
    import tlc_pkg::*;
#(
    parameter int N_ROADS          = 4,
    parameter int CNT_W            = 16,
    parameter int MIN_GREEN        = 8,
    parameter int MAX_GREEN        = 32,
    parameter int AMBER_CYCLES     = 3,
    parameter int ALL_RED_CYCLES   = 2,
    parameter int RED_AMBER_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [N_ROADS-1:0]           traffic_req,
    output logic [3*N_ROADS-1:0]         lamps,
    output logic [$clog2(N_ROADS)-1:0]   green_road,
    output logic [1:0]                   phase,
    output logic                         changeover
);

    localparam int GW = $clog2(N_ROADS);

    localparam logic [CNT_W-1:0] MIN_T = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_T = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] AMB_T = CNT_W'(AMBER_CYCLES - 1);
    localparam logic [CNT_W-1:0] AR_T  = CNT_W'(ALL_RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] RA_T  = CNT_W'(RED_AMBER_CYCLES - 1);

    if (N_ROADS < 2 || N_ROADS > 16) begin : g_bad_roads
        $error("tlc_multiway: N_ROADS must be 2..16");
    end
    if (MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN) begin : g_bad_green
        $error("tlc_multiway: need 1 <= MIN_GREEN <= MAX_GREEN");
    end
    if (AMBER_CYCLES < 1 || ALL_RED_CYCLES < 1 || RED_AMBER_CYCLES < 1) begin : g_bad_phase
        $error("tlc_multiway: amber, all-red and red-amber durations must be >= 1");
    end
    if ((MAX_GREEN - 1) >= (2 ** CNT_W)) begin : g_bad_cnt
        $error("tlc_multiway: CNT_W too narrow for MAX_GREEN-1");
    end

    tlc_phase_e          phase_q;
    logic [GW-1:0]       g_q;
    logic [GW-1:0]       n_q;
    logic [CNT_W-1:0]    timer_q;

    logic [N_ROADS-1:0]  own_mask;
    logic                other_req;
    logic                own_req;
    logic                exit_green;
    logic                pick_found;
    logic [GW-1:0]       pick_idx;

    always_comb begin
        own_mask      = '0;
        own_mask[g_q] = 1'b1;
    end

    assign other_req  = |(traffic_req & ~own_mask);
    assign own_req    = traffic_req[g_q];
    assign exit_green = other_req && (timer_q >= MIN_T) && (!own_req || (timer_q >= MAX_T));
    assign changeover = (phase_q == PH_GREEN) && exit_green;

    tlc_rr_pick #(
        .N  (N_ROADS),
        .IW (GW)
    ) u_pick (
        .req   (traffic_req),
        .cur   (g_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // exit_green implies other_req, so pick_found is always set when n is latched.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_q <= PH_GREEN;
            g_q     <= '0;
            n_q     <= '0;
            timer_q <= '0;
        end else begin
            case (phase_q)
                PH_GREEN: begin
                    if (exit_green && pick_found) begin
                        phase_q <= PH_AMBER;
                        n_q     <= pick_idx;
                        timer_q <= '0;
                    end else if (timer_q != MAX_T) begin
                        timer_q <= timer_q + CNT_W'(1);
                    end
                end
                PH_AMBER: begin
                    if (timer_q == AMB_T) begin
                        phase_q <= PH_ALL_RED;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + CNT_W'(1);
                    end
                end
                PH_ALL_RED: begin
                    if (timer_q == AR_T) begin
                        phase_q <= PH_RED_AMBER;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + CNT_W'(1);
                    end
                end
                default: begin
                    if (timer_q == RA_T) begin
                        phase_q <= PH_GREEN;
                        g_q     <= n_q;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < N_ROADS; i++) begin
            lamps[3*i +: 3] = LAMP_RED;
            case (phase_q)
                PH_GREEN:     if (g_q == GW'(i)) lamps[3*i +: 3] = LAMP_GREEN;
                PH_AMBER:     if (g_q == GW'(i)) lamps[3*i +: 3] = LAMP_AMBER;
                PH_RED_AMBER: if (n_q == GW'(i)) lamps[3*i +: 3] = LAMP_RED_AMBER;
                default:      lamps[3*i +: 3] = LAMP_RED;
            endcase
        end
    end

    assign green_road = g_q;
    assign phase      = phase_q;

endmodule
